// File: rtl/rx232_deser.sv
// Frame deserializer behind an RS-232 clock-recovery stage.
// Collects start + 8 data (LSB first) + stop, with an inter-edge watchdog.
//
// state | meaning
// IDLE  | waiting for a start-bit event; rxck_en low except the false-start pulse
// DATA  | shifting in the 8 data bits
// STOP  | waiting for the stop bit; good stop loads rx_data, bad stop flags frame_err
module rx232_deser #(
  parameter int TIMEOUT = 2100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxck,
  input  logic       rxsdo,
  input  logic       rx_ack,
  output logic       rxck_en,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       overrun
);

  localparam logic [11:0] TIMEOUT_VAL = 12'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    STOP = 2'd2
  } state_t;

  state_t      r_state;
  logic        r_rxck_q;
  logic [7:0]  r_shift;
  logic [2:0]  r_cnt;
  logic [11:0] r_timer;
  logic        r_rxck_en;
  logic [7:0]  r_rx_data;
  logic        r_rx_valid;
  logic        r_frame_err;
  logic        r_overrun;

  logic w_bit_ev;
  logic w_timeout;

  assign w_bit_ev  = rxck & ~r_rxck_q;
  assign w_timeout = (r_timer == TIMEOUT_VAL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_rxck_q    <= 1'b1;
      r_shift     <= 8'h00;
      r_cnt       <= 3'd0;
      r_timer     <= 12'd0;
      r_rxck_en   <= 1'b0;
      r_rx_data   <= 8'h00;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_rxck_q    <= rxck;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;

      if (rx_ack && r_rx_valid)
        r_rx_valid <= 1'b0;

      case (r_state)
        IDLE: begin
          r_rxck_en <= 1'b0;
          if (w_bit_ev) begin
            // a high bit here is a false start: nudge upstream with a one-cycle enable
            r_rxck_en <= 1'b1;
            if (!rxsdo) begin
              r_cnt   <= 3'd0;
              r_timer <= 12'd0;
              r_state <= DATA;
            end
          end
        end

        DATA: begin
          if (w_bit_ev) begin
            r_shift <= {rxsdo, r_shift[7:1]};
            r_cnt   <= r_cnt + 3'd1;
            r_timer <= 12'd0;
            if (r_cnt == 3'd7)
              r_state <= STOP;
          end else if (w_timeout) begin
            r_frame_err <= 1'b1;
            r_rxck_en   <= 1'b0;
            r_timer     <= 12'd0;
            r_state     <= IDLE;
          end else begin
            r_timer <= r_timer + 12'd1;
          end
        end

        STOP: begin
          if (w_bit_ev) begin
            r_rxck_en <= 1'b0;
            r_timer   <= 12'd0;
            r_state   <= IDLE;
            if (rxsdo) begin
              r_rx_data  <= r_shift;
              r_rx_valid <= 1'b1;
              r_overrun  <= r_rx_valid & ~rx_ack;
            end else begin
              r_frame_err <= 1'b1;
            end
          end else if (w_timeout) begin
            r_frame_err <= 1'b1;
            r_rxck_en   <= 1'b0;
            r_timer     <= 12'd0;
            r_state     <= IDLE;
          end else begin
            r_timer <= r_timer + 12'd1;
          end
        end

        default: begin
          r_rxck_en <= 1'b0;
          r_state   <= IDLE;
        end
      endcase
    end
  end

  assign rxck_en   = r_rxck_en;
  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_rx232_deser.sv
// Directed bench for rx232_deser: framing, errors, overrun, ack, timeout, reset.
module tb_rx232_deser;

  logic       clk;
  logic       rst;
  logic       rxck;
  logic       rxsdo;
  logic       rx_ack;
  logic       rxck_en;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;

  int n_cmp = 0;
  int n_bad = 0;
  int n_ferr = 0;
  int n_ovr = 0;
  int n_en = 0;

  rx232_deser #(.TIMEOUT(2100)) dut (
    .clk(clk),
    .rst(rst),
    .rxck(rxck),
    .rxsdo(rxsdo),
    .rx_ack(rx_ack),
    .rxck_en(rxck_en),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .frame_err(frame_err),
    .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // count high cycles of the pulse outputs, sampled mid-cycle
  always @(negedge clk) begin
    if (!rst) begin
      if (frame_err) n_ferr++;
      if (overrun)   n_ovr++;
      if (rxck_en)   n_en++;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pulse_bit(input logic b);
    @(posedge clk);
    #1;
    rxsdo = b;
    rxck  = 1'b1;
  endtask

  task automatic gap_low(input int gap);
    repeat (gap / 2) @(posedge clk);
    #1 rxck = 1'b0;
    repeat (gap - gap / 2 - 1) @(posedge clk);
  endtask

  task automatic finish_low();
    repeat (3) @(posedge clk);
    #1 rxck = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  task automatic send_body(input logic [7:0] d, input int gap);
    pulse_bit(1'b0);
    gap_low(gap);
    for (int i = 0; i < 8; i++) begin
      pulse_bit(d[i]);
      gap_low(gap);
    end
  endtask

  task automatic ack_pulse();
    @(posedge clk);
    #1 rx_ack = 1'b1;
    @(posedge clk);
    #1 rx_ack = 1'b0;
  endtask

  initial begin
    int f0, o0, e0, lat;
    logic seen;

    rst = 1'b1; rxck = 1'b0; rxsdo = 1'b1; rx_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_en",    rxck_en,   0);
    check_val("rst_data",  rx_data,   8'h00);
    check_val("rst_valid", rx_valid,  0);
    check_val("rst_ferr",  frame_err, 0);
    check_val("rst_ovr",   overrun,   0);
    rst = 1'b0;
    repeat (4) @(posedge clk);

    // 0x3C with a bad stop bit
    f0 = n_ferr;
    send_body(8'h3C, 8);
    pulse_bit(1'b0);
    @(posedge clk); #1;
    check_val("bad_stop_ferr", frame_err, 1);
    check_val("bad_stop_en",   rxck_en,   0);
    @(posedge clk); #1;
    check_val("bad_stop_ferr_off", frame_err, 0);
    finish_low();
    check_val("bad_stop_ferr_cnt", n_ferr - f0, 1);
    check_val("bad_stop_valid",    rx_valid,    0);
    check_val("bad_stop_data",     rx_data,     8'h00);

    // 0xA5 at the nominal 1041-cycle bit spacing
    send_body(8'hA5, 1041);
    pulse_bit(1'b1);
    check_val("a5_en_before",    rxck_en,  1);
    check_val("a5_valid_before", rx_valid, 0);
    @(posedge clk); #1;
    check_val("a5_valid", rx_valid, 1);
    check_val("a5_data",  rx_data,  8'hA5);
    check_val("a5_en",    rxck_en,  0);
    finish_low();
    ack_pulse();
    check_val("a5_ack_clr", rx_valid, 0);

    // ack while nothing is pending is ignored
    ack_pulse();
    check_val("idle_ack_valid", rx_valid, 0);

    // overrun: 0x11 then 0x22 without ack
    o0 = n_ovr;
    send_body(8'h11, 8);
    pulse_bit(1'b1);
    @(posedge clk); #1;
    check_val("ovr_11_data", rx_data, 8'h11);
    check_val("ovr_11_ovr",  overrun, 0);
    finish_low();
    send_body(8'h22, 8);
    pulse_bit(1'b1);
    @(posedge clk); #1;
    check_val("ovr_22_ovr",   overrun,  1);
    check_val("ovr_22_data",  rx_data,  8'h22);
    check_val("ovr_22_valid", rx_valid, 1);
    @(posedge clk); #1;
    check_val("ovr_22_ovr_off", overrun, 0);
    finish_low();
    check_val("ovr_cnt", n_ovr - o0, 1);
    ack_pulse();
    check_val("ovr_ack_clr", rx_valid, 0);

    // good stop coinciding with ack: load, stay valid, no overrun
    send_body(8'h44, 8);
    pulse_bit(1'b1);
    finish_low();
    o0 = n_ovr;
    send_body(8'h55, 8);
    pulse_bit(1'b1);
    rx_ack = 1'b1;
    @(posedge clk); #1;
    rx_ack = 1'b0;
    check_val("ackstop_data",  rx_data,  8'h55);
    check_val("ackstop_valid", rx_valid, 1);
    finish_low();
    check_val("ackstop_ovr_cnt", n_ovr - o0, 0);
    ack_pulse();

    // timeout: start + 3 data bits then rxck stops
    f0 = n_ferr;
    pulse_bit(1'b0); gap_low(8);
    pulse_bit(1'b1); gap_low(8);
    pulse_bit(1'b0); gap_low(8);
    pulse_bit(1'b1);
    lat = 0;
    seen = 1'b0;
    for (int c = 1; c <= 3000; c++) begin
      @(posedge clk); #1;
      if (c == 4) rxck = 1'b0;
      if (c == 10) check_val("to_en_active", rxck_en, 1);
      if (frame_err) begin
        lat = c;
        seen = 1'b1;
        break;
      end
    end
    check_val("to_seen", seen, 1);
    check_val("to_latency_window", (lat >= 2100 && lat <= 2103), 1);
    check_val("to_en", rxck_en, 0);
    @(posedge clk); #1;
    check_val("to_ferr_off", frame_err, 0);
    check_val("to_ferr_cnt", n_ferr - f0, 1);
    check_val("to_data", rx_data, 8'h55);

    // back in IDLE: next frame is received normally
    send_body(8'h77, 8);
    pulse_bit(1'b1);
    @(posedge clk); #1;
    check_val("post_to_data",  rx_data,  8'h77);
    check_val("post_to_valid", rx_valid, 1);
    finish_low();

    // false start in IDLE with a byte pending
    f0 = n_ferr; o0 = n_ovr; e0 = n_en;
    pulse_bit(1'b1);
    check_val("fs_en_pre", rxck_en, 0);
    @(posedge clk); #1;
    check_val("fs_en_on", rxck_en, 1);
    @(posedge clk); #1;
    check_val("fs_en_off", rxck_en, 0);
    finish_low();
    check_val("fs_en_cnt",   n_en - e0,   1);
    check_val("fs_valid",    rx_valid,    1);
    check_val("fs_ferr_cnt", n_ferr - f0, 0);
    check_val("fs_ovr_cnt",  n_ovr - o0,  0);
    ack_pulse();

    // reset in the middle of a frame, then 0x5A
    pulse_bit(1'b0); gap_low(8);
    for (int i = 0; i < 4; i++) begin
      pulse_bit(1'b1); gap_low(8);
    end
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check_val("mid_rst_en",   rxck_en, 0);
    check_val("mid_rst_data", rx_data, 8'h00);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    f0 = n_ferr;
    send_body(8'h5A, 8);
    pulse_bit(1'b1);
    @(posedge clk); #1;
    check_val("rst_5a_data",  rx_data,  8'h5A);
    check_val("rst_5a_valid", rx_valid, 1);
    finish_low();
    check_val("rst_5a_ferr_cnt", n_ferr - f0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rx232_deser.md
RX232_DESER -- requirements
Module: rx232_deser

Interface
REQ-001 The module SHALL have parameter TIMEOUT, default 2100: the clk cycles allowed between successive rxck rising edges inside a frame.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit: the reset, which is asynchronous and active-high.
REQ-004 The module SHALL have port rxck, input, 1 bit: the recovered bit clock from the upstream clock-recovery stage; each rising edge marks a settled bit.
REQ-005 The module SHALL have port rxsdo, input, 1 bit: the sampled serial bit from the upstream stage, valid whenever rxck rises.
REQ-006 The module SHALL have port rx_ack, input, 1 bit: the consumer acknowledge; a one-cycle pulse clears rx_valid.
REQ-007 The module SHALL have port rxck_en, output, 1 bit: the frame-active indication to upstream; its falling edge releases the upstream receiver.
REQ-008 The module SHALL have port rx_data, output, 8 bits: the last correctly framed byte.
REQ-009 The module SHALL have port rx_valid, output, 1 bit: a level that is high while rx_data holds an unacknowledged byte.
REQ-010 The module SHALL have port frame_err, output, 1 bit: a one-cycle pulse on a bad stop bit or a timeout.
REQ-011 The module SHALL have port overrun, output, 1 bit: a one-cycle pulse when a new byte overwrites an unacknowledged one.

Function
REQ-012 The module SHALL register rxck into rxck_q and SHALL define a bit event as rxck=1 with rxck_q=0; all FSM actions on a bit event take effect at the next clk edge.
REQ-013 The frame format SHALL be 1 start bit (0), then 8 data bits LSB first, then 1 stop bit (1); there SHALL be no parity.
REQ-014 The FSM SHALL have exactly the states IDLE, DATA and STOP.
REQ-015 In IDLE, a bit event with rxsdo=0 SHALL clear the bit counter, set rxck_en=1 and move the FSM to DATA.
REQ-016 In IDLE, a bit event with rxsdo=1 (false start) SHALL assert rxck_en for exactly one cycle, leave the FSM in IDLE and change no other output.
REQ-017 In DATA, each bit event SHALL shift rxsdo into shift[7] with a right shift and increment the 3-bit counter; the FSM SHALL move to STOP on the event where the counter equals 7.
REQ-018 In STOP, a bit event with rxsdo=1 SHALL load rx_data from shift, set rx_valid=1, clear rxck_en and return the FSM to IDLE.
REQ-019 In STOP, a bit event with rxsdo=0 SHALL pulse frame_err, leave rx_data and rx_valid unchanged, clear rxck_en and return the FSM to IDLE.
REQ-020 A 12-bit timer SHALL clear on every bit event and on entry to DATA, and SHALL increment every cycle while the FSM is in DATA or STOP.
REQ-021 When the timer reaches TIMEOUT, the module SHALL abort: pulse frame_err, clear rxck_en, return to IDLE and leave rx_data unchanged.
REQ-022 rx_valid SHALL clear on the cycle after an rx_ack pulse, and rx_ack SHALL have no effect while rx_valid=0.
REQ-023 If a good stop bit is accepted while rx_valid=1 and rx_ack=0, the module SHALL pulse overrun and overwrite rx_data, and rx_valid SHALL stay 1.
REQ-024 If a good stop bit is accepted in the same cycle as rx_ack, the new byte SHALL load, rx_valid SHALL stay 1 and overrun SHALL NOT pulse.
REQ-025 rx_valid SHALL go high exactly 1 clk after the stop-bit event cycle, and frame_err and overrun SHALL each be high for exactly one cycle per occurrence.
REQ-026 rxck_en SHALL be 0 in every cycle the FSM is in IDLE, except for the single-cycle pulse of REQ-016.

Reset
REQ-027 While rst=1, the module SHALL immediately force: FSM=IDLE, rxck_en=0, rx_data=8'h00, rx_valid=0, frame_err=0, overrun=0, shift=0, counter=0, timer=0 and rxck_q=1.
REQ-028 An rst assertion in the middle of a frame SHALL discard the partial byte, and after release the module SHALL wait in IDLE for the next start-bit event.
REQ-029 A bit event produced by the upstream rxck rising as it comes out of its own reset SHALL be handled only as per REQ-015 or REQ-016.

Verification
REQ-030 The bench SHALL drive frame 0, 1,0,1,0,0,1,0,1, 1 on rxsdo with rxck edges 1041 cycles apart -> rx_data=8'hA5 and rx_valid=1 one cycle after the stop-bit event, with rxck_en falling at that same edge.
REQ-031 The bench SHALL drive a frame carrying 8'h3C with stop bit 0 -> frame_err pulses for 1 cycle, rx_valid stays 0 and rx_data stays 8'h00.
REQ-032 The bench SHALL drive 8'h11 then 8'h22 with no rx_ack -> overrun pulses once, rx_data=8'h22 and rx_valid=1; a following rx_ack -> rx_valid=0 on the next cycle.
REQ-033 The bench SHALL drive a start bit plus 3 data bits and then stop rxck -> frame_err pulses 2100 cycles after the last event, rxck_en falls and the FSM returns to IDLE.
REQ-034 The bench SHALL drive an IDLE bit event with rxsdo=1 -> rxck_en is high for exactly 1 cycle and rx_valid, frame_err and overrun do not change.
REQ-035 The bench SHALL assert rst after the 4th data bit and then send 8'h5A -> rx_data=8'h5A with no frame_err.
